// File: rtl/fall_through_small_fifo_if.sv
// Handshake bundle for fall_through_small_fifo: push side, pop side and occupancy flags.
// master drives data and push/pop strobes; slave is the FIFO itself.
interface fall_through_small_fifo_if #(
  parameter int WIDTH = 72
);
  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             nearly_full;
  logic             empty;

  modport master (
    output din,
    output wr_en,
    output rd_en,
    input  dout,
    input  full,
    input  nearly_full,
    input  empty
  );

  modport slave (
    input  din,
    input  wr_en,
    input  rd_en,
    output dout,
    output full,
    output nearly_full,
    output empty
  );
endinterface

// File: rtl/fall_through_small_fifo.sv
// First-word-fall-through register FIFO: head entry is always on dout, rd_en pops it.
// Optional macro FALL_THROUGH_FIFO_CHECK_EN adds simulation-only overflow/underflow checks.
module fall_through_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3,
  parameter int NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  fall_through_small_fifo_if.slave     bus
);

  localparam int DEPTH = 2**MAX_DEPTH_BITS;
  // A one-entry FIFO still needs a 1-bit pointer; wrap is explicit so width never matters.
  localparam int PTR_W = (MAX_DEPTH_BITS > 0) ? MAX_DEPTH_BITS : 1;
  localparam int CNT_W = MAX_DEPTH_BITS + 1;

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_NFULL = CNT_W'(NEARLY_FULL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic full_i;
  logic empty_i;
  logic wr_ok;
  logic rd_ok;

  assign full_i  = (count == CNT_FULL);
  assign empty_i = (count == '0);

  // Flags are sampled before the edge: a pop does not make room for a same-cycle push.
  assign wr_ok = bus.wr_en & ~full_i;
  assign rd_ok = bus.rd_en & ~empty_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage is not reset; stale contents are masked by empty.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  assign bus.dout        = empty_i ? '0 : mem[rd_ptr];
  assign bus.full        = full_i;
  assign bus.empty       = empty_i;
  assign bus.nearly_full = (count >= CNT_NFULL);

`ifdef FALL_THROUGH_FIFO_CHECK_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (bus.wr_en && full_i) begin
        $display("%t %m ERROR: write to full fifo", $time);
        $stop;
      end
      if (bus.rd_en && empty_i) begin
        $display("%t %m ERROR: read from empty fifo", $time);
        $stop;
      end
    end
  end
`else
  // Without the checks, overflow pushes are dropped and underflow pops ignored silently.
`endif

endmodule

// File: tb/tb_fall_through_small_fifo.sv
// Randomized and directed checks of fall_through_small_fifo against a queue-based model.
module tb_fall_through_small_fifo;

  localparam int WIDTH = 72;
  localparam int DEPTH = 8;
  localparam int NF    = 7;

  logic clk;
  logic reset;

  fall_through_small_fifo_if #(.WIDTH(WIDTH)) bus ();

  fall_through_small_fifo #(
    .WIDTH(WIDTH),
    .MAX_DEPTH_BITS(3),
    .NEARLY_FULL(NF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] model_q[$];

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [WIDTH-1:0] exp_dout;
    exp_dout = (model_q.size() == 0) ? '0 : model_q[0];
    check_eq({tag, ".empty"}, WIDTH'(bus.empty), WIDTH'(model_q.size() == 0));
    check_eq({tag, ".full"}, WIDTH'(bus.full), WIDTH'(model_q.size() == DEPTH));
    check_eq({tag, ".nearly_full"}, WIDTH'(bus.nearly_full), WIDTH'(model_q.size() >= NF));
    check_eq({tag, ".dout"}, bus.dout, exp_dout);
  endtask

  // Called at a falling edge; applies one cycle of stimulus and checks after the next edge.
  task automatic do_cycle(input logic w, input logic r, input logic [WIDTH-1:0] d, input string tag);
    bit was_full, was_empty;
    bus.wr_en = w;
    bus.rd_en = r;
    bus.din   = d;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    @(posedge clk);
    if (r && !was_empty) void'(model_q.pop_front());
    if (w && !was_full) model_q.push_back(d);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check_model(tag);
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    return {8'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  initial begin
    logic [WIDTH-1:0] seq;
    bus.din   = '0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check_eq("reset.empty", WIDTH'(bus.empty), WIDTH'(1));
    check_eq("reset.full", WIDTH'(bus.full), WIDTH'(0));
    check_eq("reset.nearly_full", WIDTH'(bus.nearly_full), WIDTH'(0));
    check_eq("reset.dout", bus.dout, '0);

    do_cycle(1'b1, 1'b0, 72'hA5, "first_write");
    check_eq("fwft.dout", bus.dout, 72'hA5);
    do_cycle(1'b0, 1'b1, '0, "first_pop");
    check_eq("first_pop.empty", WIDTH'(bus.empty), WIDTH'(1));

    // Fill to capacity, overflow, then drain in order.
    for (int i = 1; i <= DEPTH; i++) begin
      do_cycle(1'b1, 1'b0, WIDTH'(i), "fill");
      if (i == NF) check_eq("fill7.nearly_full", WIDTH'(bus.nearly_full), WIDTH'(1));
      if (i == NF) check_eq("fill7.full", WIDTH'(bus.full), WIDTH'(0));
    end
    check_eq("fill8.full", WIDTH'(bus.full), WIDTH'(1));
    do_cycle(1'b1, 1'b0, 72'h99, "overflow");
    check_eq("overflow.dout", bus.dout, 72'h1);
    for (int i = 1; i <= DEPTH; i++) begin
      check_eq("drain.order", bus.dout, WIDTH'(i));
      do_cycle(1'b0, 1'b1, '0, "drain");
    end
    check_eq("drain.dout_zero", bus.dout, '0);
    do_cycle(1'b0, 1'b1, '0, "underflow");

    // Push+pop on empty: only the push happens.
    do_cycle(1'b1, 1'b1, 72'h3C, "wr_rd_empty");
    check_eq("wr_rd_empty.dout", bus.dout, 72'h3C);
    do_cycle(1'b0, 1'b1, '0, "wr_rd_empty_pop");

    // Steady push+pop at occupancy 3 across pointer wrap.
    seq = 72'h100;
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 1'b0, seq, "pre3");
      seq++;
    end
    for (int i = 0; i < 20; i++) begin
      check_eq("stream.order", bus.dout, WIDTH'(72'h100 + i));
      do_cycle(1'b1, 1'b1, seq, "stream");
      seq++;
    end
    check_eq("stream.occupancy", WIDTH'(model_q.size()), WIDTH'(3));

    // Fill up, then push+pop while full: only the pop happens.
    while (model_q.size() < DEPTH) do_cycle(1'b1, 1'b0, rand_word(), "refill");
    do_cycle(1'b1, 1'b1, 72'h77, "wr_rd_full");
    check_eq("wr_rd_full.full", WIDTH'(bus.full), WIDTH'(0));
    check_eq("wr_rd_full.nearly", WIDTH'(bus.nearly_full), WIDTH'(1));
    while (model_q.size() > 0) do_cycle(1'b0, 1'b1, '0, "drain2");

    // Asynchronous reset mid-cycle at occupancy 5.
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, rand_word(), "pre_reset");
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst.empty", WIDTH'(bus.empty), WIDTH'(1));
    check_eq("async_rst.full", WIDTH'(bus.full), WIDTH'(0));
    check_eq("async_rst.dout", bus.dout, '0);
    model_q.delete();
    #1 reset = 1'b0;
    @(negedge clk);
    do_cycle(1'b1, 1'b0, 72'h5A, "post_reset");
    check_eq("post_reset.dout", bus.dout, 72'h5A);

    // Random traffic with phases biased toward filling and toward draining.
    for (int i = 0; i < 1500; i++) begin
      int wp;
      wp = ((i / 150) % 2 == 0) ? 75 : 30;
      do_cycle(logic'($urandom_range(99) < wp), logic'($urandom_range(99) < (100 - wp)),
               rand_word(), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
